// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Word-granular posted-write buffer between the core memory stage and the
//   data memory. Stores retire into a small FIFO in one cycle and drain to
//   memory one per cycle whenever the memory port is not needed by a load.
//   Loads that hit a pending store get the youngest matching data forwarded
//   without touching memory.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   st_valid/st_addr/st_data/st_ready   core store request / accept
//   ld_valid/ld_addr/ld_data/ld_stall   core load request / result / hold
//   fence, fence_done     drain request (level) and completion
//   mem_addr/mem_wdata/mem_write/mem_read/mem_rdata   data memory port
//   count                 number of occupied entries
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_stall,
    input  logic                     fence,
    output logic                     fence_done,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic                     mem_write,
    output logic                     mem_read,
    input  logic [DW-1:0]            mem_rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    // Entry storage: word index and data per slot, plus a valid bit per slot.
    logic [WW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW:0]      count_reg;

    logic             full;
    logic             empty;
    logic             enq;
    logic             drain;
    logic [DEPTH-1:0] match;
    logic             hit;
    logic [PW-1:0]    hit_idx;

    // Byte-offset bits of the addresses carry no meaning for word accesses.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign full       = (count_reg == (PW+1)'(DEPTH));
    assign empty      = (count_reg == '0);
    assign st_ready   = !full && !fence;
    assign enq        = st_valid && st_ready;
    assign fence_done = fence && empty;
    assign count      = count_reg;

    // Per-entry address comparators for load forwarding.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (addr_mem[gi] == ld_addr[AW-1:2]);
        end
    endgenerate

    // Walk from oldest (rd_ptr) to youngest; the last match seen is the
    // youngest, which holds the value the program most recently stored.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[rd_ptr_reg + PW'(k)]) begin
                hit     = 1'b1;
                hit_idx = rd_ptr_reg + PW'(k);
            end
        end
    end

    // Single memory port arbitration. A missing load normally owns the port;
    // when the buffer is full the load is stalled and the head drains instead
    // so that stores cannot be starved forever by a stream of loads.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_stall  = 1'b0;
        ld_data   = '0;
        drain     = 1'b0;
        if (ld_valid && hit) begin
            ld_data = data_mem[hit_idx];
        end
        if (ld_valid && !hit && !full) begin
            mem_read = 1'b1;
            mem_addr = ld_addr;
            ld_data  = mem_rdata;
        end else begin
            if (ld_valid && !hit) begin
                ld_stall = 1'b1;
            end
            if (!empty) begin
                drain     = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {addr_mem[rd_ptr_reg], 2'b00};
                mem_wdata = data_mem[rd_ptr_reg];
            end
        end
    end

    // Control state. Enqueue and drain can never target the same slot in one
    // cycle: enqueue needs !full and drain needs !empty, so wr_ptr != rd_ptr
    // whenever both happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            end
            if (drain) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage needs no reset; slots are only read while valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_reg] <= st_addr[AW-1:2];
            data_mem[wr_ptr_reg] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Randomized bench for store_buffer. The reference model keeps pending
//   stores in a queue (oldest at the front) and a word array standing for
//   memory contents; every cycle it predicts the port outputs from the
//   arbitration rules and compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                   clk;
    logic                   rst_n;
    logic                   st_valid;
    logic [AW-1:0]          st_addr;
    logic [DW-1:0]          st_data;
    logic                   st_ready;
    logic                   ld_valid;
    logic [AW-1:0]          ld_addr;
    logic [DW-1:0]          ld_data;
    logic                   ld_stall;
    logic                   fence;
    logic                   fence_done;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_write;
    logic                   mem_read;
    logic [DW-1:0]          mem_rdata;
    logic [$clog2(DEPTH):0] count;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_stall   (ld_stall),
        .fence      (fence),
        .fence_done (fence_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT, and the memory the model expects.
    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];
    assign mem_rdata = dmem[mem_addr[9:2]];

    typedef struct {
        int          w;
        logic [31:0] d;
    } pend_t;
    pend_t pend_q[$];

    int checks = 0;
    int errors = 0;
    bit fence_on = 0;
    bit fence_release = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of random traffic. p_st/p_ld are percentages;
    // miss_only steers every load to word 64, which stores never target.
    task automatic cycle(input int p_st, input int p_ld, input bit miss_only);
        int          n;
        int          lw;
        bit          full;
        bit          hit;
        logic [31:0] hd;
        bit          e_ready, e_rd, e_wr, e_stall, e_drain;
        logic [31:0] e_addr, e_wd, e_ld;
        logic        wr_seen;
        logic [31:0] wr_a, wr_d;
        pend_t       ent;

        @(negedge clk);
        if (fence_on && fence_release) begin
            fence_on      = 0;
            fence_release = 0;
        end else if (!fence_on && $urandom_range(0, 31) == 0) begin
            fence_on = 1;
        end
        fence    = fence_on;
        st_valid = ($urandom_range(0, 99) < p_st);
        st_addr  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        st_data  = $urandom;
        ld_valid = ($urandom_range(0, 99) < p_ld);
        lw       = miss_only ? 64 : $urandom_range(0, 15);
        ld_addr  = (lw << 2) | $urandom_range(0, 3);

        #1;
        n    = pend_q.size();
        full = (n == DEPTH);
        hit  = 0;
        hd   = '0;
        foreach (pend_q[i]) begin
            if (pend_q[i].w == lw) begin
                hit = 1;
                hd  = pend_q[i].d;
            end
        end
        e_ready = !full && !fence;
        e_rd = 0; e_wr = 0; e_stall = 0; e_drain = 0;
        e_addr = '0; e_wd = '0; e_ld = '0;
        if (ld_valid && !hit && !full) begin
            e_rd   = 1;
            e_addr = ld_addr;
            e_ld   = ref_mem[lw];
        end else begin
            e_stall = ld_valid && !hit;
            if (hit) e_ld = hd;
            if (n > 0) begin
                e_drain = 1;
                e_wr    = 1;
                e_addr  = pend_q[0].w << 2;
                e_wd    = pend_q[0].d;
            end
        end

        check_val("st_ready",   st_ready,   e_ready);
        check_val("ld_stall",   ld_stall,   e_stall);
        check_val("mem_read",   mem_read,   e_rd);
        check_val("mem_write",  mem_write,  e_wr);
        check_val("mem_addr",   mem_addr,   e_addr);
        check_val("count",      count,      n);
        check_val("fence_done", fence_done, fence && (n == 0));
        if (!e_rd) check_val("mem_wdata", mem_wdata, e_wd);
        if (ld_valid && !e_stall) check_val("ld_data", ld_data, e_ld);
        if (fence && n == 0) fence_release = 1;

        wr_seen = mem_write;
        wr_a    = mem_addr;
        wr_d    = mem_wdata;

        @(posedge clk);
        if (wr_seen) dmem[wr_a[9:2]] = wr_d;
        if (e_drain) begin
            ref_mem[pend_q[0].w] = pend_q[0].d;
            $display("drain  w=%0d d=%08h", pend_q[0].w, pend_q[0].d);
            void'(pend_q.pop_front());
        end
        if (st_valid && e_ready) begin
            ent.w = int'(st_addr[9:2]);
            ent.d = st_data;
            pend_q.push_back(ent);
            $display("store  w=%0d d=%08h", ent.w, ent.d);
        end
        if (ld_valid && !e_stall)
            $display("load   w=%0d d=%08h %s", lw, ld_data, hit ? "fwd" : "mem");
    endtask

    task automatic idle_inputs();
        st_valid = 0; st_addr = '0; st_data = '0;
        ld_valid = 0; ld_addr = '0; fence = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = i * 32'h0101_0101 + 32'd7;
            ref_mem[i] = i * 32'h0101_0101 + 32'd7;
        end
        idle_inputs();
        rst_n = 0;
        #1;
        check_val("rst_count",      count,      0);
        check_val("rst_st_ready",   st_ready,   1);
        check_val("rst_ld_stall",   ld_stall,   0);
        check_val("rst_fence_done", fence_done, 0);
        check_val("rst_mem_write",  mem_write,  0);
        check_val("rst_mem_read",   mem_read,   0);
        check_val("rst_mem_addr",   mem_addr,   0);
        check_val("rst_mem_wdata",  mem_wdata,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        repeat (500) cycle(60, 50, 0);
        repeat (200) cycle(100, 100, 1);   // sustained misses against a full buffer
        repeat (3)   cycle(100, 0, 0);     // build up pending stores before reset

        // Asynchronous reset mid-cycle discards pending stores.
        @(negedge clk);
        idle_inputs();
        fence_on = 0; fence_release = 0;
        #2 rst_n = 0;
        #1;
        check_val("async_count",     count,     0);
        check_val("async_mem_write", mem_write, 0);
        check_val("async_st_ready",  st_ready,  1);
        pend_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        repeat (500) cycle(70, 40, 0);

        // Let everything drain, then compare memory contents.
        repeat (DEPTH + 2) cycle(0, 0, 0);
        check_val("final_pending", pend_q.size(), 0);
        for (int i = 0; i < 16; i++) check_val($sformatf("mem_w%0d", i), dmem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
